// File: rtl/render_burst_writer_if.sv
// rtl/render_burst_writer_if.sv - renderer pop handshake and MIG port-0 write/command bus
interface render_burst_writer_if;
  logic [31:0] data;
  logic        ready;
  logic        frame_ready;
  logic        send_data;
  logic        mem_calib_done;
  logic [6:0]  p0_wr_count;
  logic        p0_wr_full;
  logic        p0_cmd_full;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic [3:0]  p0_wr_mask;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;

  modport master (
    input  data, ready, frame_ready, mem_calib_done, p0_wr_count, p0_wr_full, p0_cmd_full,
    output send_data, p0_wr_en, p0_wr_data, p0_wr_mask, p0_cmd_en, p0_cmd_instr,
           p0_cmd_bl, p0_cmd_byte_addr
  );

  modport slave (
    output data, ready, frame_ready, mem_calib_done, p0_wr_count, p0_wr_full, p0_cmd_full,
    input  send_data, p0_wr_en, p0_wr_data, p0_wr_mask, p0_cmd_en, p0_cmd_instr,
           p0_cmd_bl, p0_cmd_byte_addr
  );
endinterface

// File: rtl/render_burst_writer.sv
// rtl/render_burst_writer.sv - pops renderer words into MIG port 0 in bursts, double-buffering frames
module render_burst_writer #(
  parameter int          BURST_LEN   = 16,
  parameter int          FRAME_WORDS = 307200,
  parameter logic [29:0] FRAME0_BASE = 30'h0000000,
  parameter logic [29:0] FRAME1_BASE = 30'h0200000
) (
  input  logic                  clk,
  input  logic                  SYS_RESETn,
  render_burst_writer_if.master bus,
  output logic                  memory_frame,
  output logic                  overflow
);
  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int WIW = $clog2(FRAME_WORDS + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST_LEN);
  localparam logic [WIW-1:0] FRAME_MAX = WIW'(FRAME_WORDS);

  typedef enum logic [2:0] {IDLE, FILL, WAIT_WR, CMD, SWAP} state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [WIW-1:0] word_idx_q, word_idx_d;
  logic           frame_pend_q, frame_pend_d;
  logic           memory_frame_q, memory_frame_d;
  logic           overflow_q, overflow_d;
  logic           wr_en_q, wr_en_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           send;
  logic           cmd_fire;
  logic [WIW-1:0] burst_start;
  logic [BCW-1:0] bl_full;
  logic [29:0]    base;

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.mem_calib_done && bus.p0_wr_count == 7'd0) state_d = FILL;
      FILL: begin
        if (burst_cnt_q == BURST_MAX)  state_d = WAIT_WR;
        else if (frame_pend_q)         state_d = (burst_cnt_q != '0) ? WAIT_WR : SWAP;
      end
      WAIT_WR: state_d = CMD;
      CMD:     if (!bus.p0_cmd_full) state_d = frame_pend_q ? SWAP : IDLE;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    send     = 1'b0;
    cmd_fire = 1'b0;
    if (state_q == FILL)
      send = bus.ready && (burst_cnt_q < BURST_MAX) && (word_idx_q < FRAME_MAX) && !frame_pend_q;
    if (state_q == CMD)
      cmd_fire = !bus.p0_cmd_full;
  end

  // A word taken together with frame_ready still counts; SWAP then clears the pending frame.
  always_comb begin
    burst_cnt_d    = burst_cnt_q;
    word_idx_d     = word_idx_q;
    frame_pend_d   = frame_pend_q;
    memory_frame_d = memory_frame_q;
    overflow_d     = overflow_q;
    wr_en_d        = send;
    wr_data_d      = send ? bus.data : wr_data_q;
    if (send) begin
      burst_cnt_d = burst_cnt_q + BCW'(1);
      word_idx_d  = word_idx_q + WIW'(1);
    end
    if (cmd_fire) burst_cnt_d = '0;
    if (bus.frame_ready) frame_pend_d = 1'b1;
    if (state_q == FILL && bus.ready && word_idx_q == FRAME_MAX) overflow_d = 1'b1;
    if (state_q == SWAP) begin
      memory_frame_d = !memory_frame_q;
      word_idx_d     = '0;
      frame_pend_d   = 1'b0;
      overflow_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      burst_cnt_q    <= '0;
      word_idx_q     <= '0;
      frame_pend_q   <= 1'b0;
      memory_frame_q <= 1'b0;
      overflow_q     <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_data_q      <= '0;
    end else begin
      burst_cnt_q    <= burst_cnt_d;
      word_idx_q     <= word_idx_d;
      frame_pend_q   <= frame_pend_d;
      memory_frame_q <= memory_frame_d;
      overflow_q     <= overflow_d;
      wr_en_q        <= wr_en_d;
      wr_data_q      <= wr_data_d;
    end
  end

  // Writes always target the buffer the reader is not using.
  assign base        = memory_frame_q ? FRAME0_BASE : FRAME1_BASE;
  assign burst_start = word_idx_q - WIW'(burst_cnt_q);
  assign bl_full     = burst_cnt_q - BCW'(1);

  assign bus.send_data        = send;
  assign bus.p0_wr_en         = wr_en_q;
  assign bus.p0_wr_data       = wr_data_q;
  assign bus.p0_wr_mask       = 4'b0000;
  assign bus.p0_cmd_en        = cmd_fire;
  assign bus.p0_cmd_instr     = 3'b000;
  assign bus.p0_cmd_bl        = cmd_fire ? 6'(bl_full) : 6'd0;
  assign bus.p0_cmd_byte_addr = cmd_fire ? base + (30'(burst_start) << 2) : 30'd0;
  assign memory_frame         = memory_frame_q;
  assign overflow             = overflow_q;

  // The FIFO is empty when FILL starts and a burst never exceeds 64 words.
  a_no_full_in_fill: assert property (@(posedge clk) disable iff (!SYS_RESETn)
    (state_q == FILL) |-> !bus.p0_wr_full);
endmodule
